goboard_switch_port: RTL

//  Memory-mapped input port: the CPU-read counterpart of the 0x14 seven-segment output port.

---
 rtl/goboard_io_pkg.sv | 24 ++
 rtl/goboard_debounce.sv | 50 +++++
 rtl/goboard_switch_port.sv | 112 +++++++++++
 3 files changed

// File: rtl/goboard_io_pkg.sv
// Shared address map and types for the GoBoard memory-mapped I/O ports
// (seven-segment output at 0x14, switch input port directly above it).
package goboard_io_pkg;

    localparam logic [31:0] SEG_OUT_ADDR  = 32'h14;

    localparam logic [31:0] SW_STATUS_OFS = 32'h0;
    localparam logic [31:0] SW_EVENTS_OFS = 32'h4;
    localparam logic [31:0] SW_COUNT_OFS  = 32'h8;
    localparam logic [31:0] SW_MASK_OFS   = 32'hC;

    localparam int SW_CHANNELS = 4;

    typedef logic [SW_CHANNELS-1:0] sw_vec_t;
    typedef logic [15:0]            sw_count_t;

    // Word-aligned compare: the CPU's byte-lane bits never select a register
    function automatic logic reg_match(input logic [31:0] adr,
                                       input logic [31:0] base,
                                       input logic [31:0] ofs);
        return (adr & ~32'h3) == ((base + ofs) & ~32'h3);
    endfunction

endpackage

// File: rtl/goboard_debounce.sv
// One switch channel: 2-FF synchroniser, stability counter, accepted level
// and a single-cycle pulse on each accepted 0->1 transition.
module goboard_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic level,
    output logic press
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          synced;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            synced <= 1'b0;
        end else begin
            sync1  <= sw;
            synced <= sync1;
        end
    end

    // Any sample matching the accepted level restarts the stability window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= synced;
                press <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/goboard_switch_port.sv
// CPU-readable switch port: debounced level, sticky press events and a press
// counter. Defining GOBOARD_SW_IRQ_EN adds the MASK register and the irq output.
module goboard_switch_port
    import goboard_io_pkg::*;
#(
    parameter int          NUM_SW          = SW_CHANNELS,
    parameter int          DEBOUNCE_CYCLES = 120000,
    parameter logic [31:0] BASE_ADDR       = SEG_OUT_ADDR + 32'h4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    input  logic              MemWrite,
    input  logic [NUM_SW-1:0] i_sw,
    output logic [31:0]       ReadData,
    output logic              rd_hit,
    output logic              irq
);

`ifdef GOBOARD_SW_IRQ_EN
    localparam logic HAS_MASK = 1'b1;
`else
    localparam logic HAS_MASK = 1'b0;
`endif

    logic [NUM_SW-1:0] level;
    logic [NUM_SW-1:0] press;
    logic [NUM_SW-1:0] events;
    logic [NUM_SW-1:0] mask;
    sw_count_t         count;
    sw_count_t         press_count;
    logic              hit_status;
    logic              hit_events;
    logic              hit_count;
    logic              hit_mask;
    logic              wr_en;
    logic              unused_wdata;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
        goboard_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .sw    (i_sw[g]),
            .level (level[g]),
            .press (press[g])
        );
    end

    assign hit_status   = reg_match(DataAdr, BASE_ADDR, SW_STATUS_OFS);
    assign hit_events   = reg_match(DataAdr, BASE_ADDR, SW_EVENTS_OFS);
    assign hit_count    = reg_match(DataAdr, BASE_ADDR, SW_COUNT_OFS);
    assign hit_mask     = HAS_MASK & reg_match(DataAdr, BASE_ADDR, SW_MASK_OFS);
    assign rd_hit       = hit_status | hit_events | hit_count | hit_mask;
    assign wr_en        = MemWrite & cpu_en;
    assign unused_wdata = ^WriteData[31:NUM_SW];

    always_comb begin
        press_count = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            press_count = press_count + sw_count_t'(press[i]);
        end
    end

    always_comb begin
        ReadData = '0;
        if (hit_status) ReadData[NUM_SW-1:0] = level;
        if (hit_events) ReadData[NUM_SW-1:0] = events;
        if (hit_count)  ReadData[15:0]       = count;
        if (hit_mask)   ReadData[NUM_SW-1:0] = mask;
    end

    // A press landing in the same cycle as a W1C clear keeps its bit set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            events <= '0;
        end else if (wr_en && hit_events) begin
            events <= (events & ~WriteData[NUM_SW-1:0]) | press;
        end else begin
            events <= events | press;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr_en && hit_count) begin
            count <= press_count;
        end else begin
            count <= count + press_count;
        end
    end

`ifdef GOBOARD_SW_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && hit_mask) mask <= WriteData[NUM_SW-1:0];
            irq <= |(events & mask);
        end
    end
`else
    assign mask = '0;
    assign irq  = 1'b0;
`endif

endmodule
